// File: rtl/psum_binarize_reader_pkg.sv
// Shared types and constants for the partial-sums readout path.
// The bank and the binarizing reader agree on lane count and widths here.
package psum_binarize_reader_pkg;

  localparam int unsigned LANES   = 32;
  localparam int unsigned PSUM_W  = 16;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned COUNT_W = 6;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic [ADDR_W-1:0]        row_addr_t;

  // Fixed encodings kept so existing debug tooling still decodes the state bus.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/psum_binarize_reader_if.sv
// Control, memory read port and activation stream of the binarizing reader.
interface psum_binarize_reader_if #(
  parameter int unsigned LANES   = 32,
  parameter int unsigned PSUM_W  = 16,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned COUNT_W = 6
) ();

  logic                      start;
  logic [ADDR_W-1:0]         address_start;
  logic [COUNT_W-1:0]        batch;
  logic [LANES*PSUM_W-1:0]   thresholds;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [LANES*PSUM_W-1:0]   mem_rdata;
  logic [LANES-1:0]          act_data;
  logic                      act_valid;
  logic                      act_ready;
  logic                      act_last;
  logic                      busy;
  logic                      done;

  modport master (
    output start, address_start, batch, thresholds, mem_rdata, act_ready,
    input  mem_en, mem_addr, act_data, act_valid, act_last, busy, done
  );

  modport slave (
    input  start, address_start, batch, thresholds, mem_rdata, act_ready,
    output mem_en, mem_addr, act_data, act_valid, act_last, busy, done
  );

endinterface

// File: rtl/psum_binarize_reader_act_fifo2.sv
// Two-entry registered valid/ready FIFO; the head register drives the output.
module act_fifo2 #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign pop     = ready_i && (count_q != 2'd0);
  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push_i, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data_i;
        else                 tail_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the new word lands behind whatever remains.
        if (count_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/psum_binarize_reader.sv
// Walks a range of partial-sum rows, thresholds every lane and streams
// the packed binary activation words out on a valid/ready port.
module psum_binarize_reader #(
  parameter int unsigned LANES   = psum_binarize_reader_pkg::LANES,
  parameter int unsigned PSUM_W  = psum_binarize_reader_pkg::PSUM_W,
  parameter int unsigned ADDR_W  = psum_binarize_reader_pkg::ADDR_W,
  parameter int unsigned COUNT_W = psum_binarize_reader_pkg::COUNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  psum_binarize_reader_if.slave bus
);
  import psum_binarize_reader_pkg::*;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COUNT_W-1:0] remain_q, remain_d;
  logic               inflight_q, inflight_last_q;

  logic [LANES-1:0]   cmp_bits;
  logic               fifo_valid;
  logic [LANES:0]     fifo_head;
  logic [1:0]         fifo_count;
  logic [2:0]         credit_used;
  logic               pop, issue, last_issue;

  assign pop         = fifo_valid && bus.act_ready;
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q};
  // Buffered plus outstanding words, less the one leaving now, must stay below two.
  assign issue       = (state_q == READ) && (credit_used < (pop ? 3'd3 : 3'd2));
  assign last_issue  = issue && (remain_q == COUNT_W'(1));

  always_comb begin
    cmp_bits = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      cmp_bits[i] = $signed(bus.mem_rdata[i*PSUM_W +: PSUM_W]) >=
                    $signed(bus.thresholds[i*PSUM_W +: PSUM_W]);
    end
  end

  act_fifo2 #(.W(LANES + 1)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, cmp_bits}),
    .ready_i     (bus.act_ready),
    .valid_o     (fifo_valid),
    .data_o      (fifo_head),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.batch != '0) begin
            addr_d   = bus.address_start;
            remain_d = bus.batch;
            state_d  = READ;
          end else begin
            state_d  = DONE;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          remain_d = remain_q - COUNT_W'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && pop && fifo_head[LANES]) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  assign bus.mem_en    = issue;
  assign bus.mem_addr  = addr_q;
  assign bus.act_valid = fifo_valid;
  assign bus.act_data  = fifo_head[LANES-1:0];
  assign bus.act_last  = fifo_head[LANES];
  assign bus.busy      = (state_q == READ) || (state_q == DRAIN) ||
                         ((state_q == IDLE) && bus.start);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_psum_binarize_reader.sv
// Randomized bench for psum_binarize_reader against a row/lane arithmetic model.
module tb_psum_binarize_reader;

  localparam int unsigned L  = 32;
  localparam int unsigned PW = 16;
  localparam int unsigned AW = 11;
  localparam int unsigned CW = 6;
  localparam int unsigned NROWS = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_binarize_reader_if #(.LANES(L), .PSUM_W(PW), .ADDR_W(AW), .COUNT_W(CW)) bus ();

  psum_binarize_reader #(.LANES(L), .PSUM_W(PW), .ADDR_W(AW), .COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [L*PW-1:0] mem [0:NROWS-1];
  logic [L*PW-1:0] thr_v;

  // Synchronous-read memory: data one cycle after mem_en.
  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;

  // Observation records filled by run_readout
  int          rec_addr[$];
  int          rec_issue_cyc[$];
  logic [L-1:0] rec_word[$];
  bit          rec_last[$];
  int          rec_hs_cyc[$];
  int          done_cyc, done_cnt, stall_viol, max_out, busy_gaps, valid_cyc_cnt;
  bit          busy_at_done, timed_out;

  function automatic logic [L-1:0] ref_word(input int unsigned row);
    logic [L-1:0] res;
    logic signed [PW-1:0] s;
    int p, q;
    res = '0;
    for (int l = 0; l < int'(L); l++) begin
      s = mem[row][l*PW +: PW];
      p = s;
      s = thr_v[l*PW +: PW];
      q = s;
      res[l] = (p >= q);
    end
    return res;
  endfunction

  task automatic fill_random_mem();
    for (int r = 0; r < int'(NROWS); r++)
      for (int w = 0; w < int'(L*PW/32); w++) mem[r][w*32 +: 32] = $urandom;
  endtask

  task automatic set_random_thr();
    for (int w = 0; w < int'(L*PW/32); w++) thr_v[w*32 +: 32] = $urandom;
    bus.thresholds = thr_v;
  endtask

  // Drives one readout and records what the DUT did; the calling test judges it.
  task automatic run_readout(input int addr, input int n, input int ready_mode, input bit spurious);
    int cyc, issued, consumed, first_valid;
    bit prev_stall, prev_last, hs;
    logic [L-1:0] prev_data;
    rec_addr.delete(); rec_issue_cyc.delete(); rec_word.delete();
    rec_last.delete(); rec_hs_cyc.delete();
    done_cyc = -1; done_cnt = 0; stall_viol = 0; max_out = 0; busy_gaps = 0;
    valid_cyc_cnt = 0; busy_at_done = 1'b0; timed_out = 1'b0;
    cyc = 0; issued = 0; consumed = 0; first_valid = -1; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (first_valid < 0 && bus.act_valid) first_valid = cyc;
      bus.start = (cyc == 0) || (spurious && cyc == 3);
      if (cyc == 0) begin
        bus.address_start = AW'(addr);
        bus.batch         = CW'(n);
      end else if (spurious && cyc == 3) begin
        bus.address_start = AW'($urandom);
        bus.batch         = CW'($urandom_range(1, 63));
      end
      case (ready_mode)
        0:       bus.act_ready = 1'b1;
        1:       bus.act_ready = (first_valid >= 0) && (cyc >= first_valid + 5);
        default: bus.act_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (bus.mem_en) begin
        rec_addr.push_back(int'(bus.mem_addr));
        rec_issue_cyc.push_back(cyc);
        issued++;
      end
      hs = bus.act_valid && bus.act_ready;
      if (bus.act_valid) valid_cyc_cnt++;
      if (hs) begin
        rec_word.push_back(bus.act_data);
        rec_last.push_back(bus.act_last);
        rec_hs_cyc.push_back(cyc);
        consumed++;
      end
      if (issued - consumed > max_out) max_out = issued - consumed;
      if (prev_stall && (!bus.act_valid || bus.act_data !== prev_data || bus.act_last !== prev_last))
        stall_viol++;
      prev_stall = bus.act_valid && !bus.act_ready;
      prev_data  = bus.act_data;
      prev_last  = bus.act_last;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          busy_at_done = bus.busy;
        end
      end else if (done_cyc < 0 && !bus.busy) begin
        busy_gaps++;
      end
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
      if (cyc > 400) begin
        timed_out = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.address_start = '0; bus.batch = '0; bus.act_ready = 1'b0;
    thr_v = '0; bus.thresholds = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.mem_en, bus.act_valid, bus.act_last, bus.busy, bus.done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {bus.mem_en, bus.act_valid, bus.act_last, bus.busy, bus.done});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.act_data !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%0h data=%0h exp=0", bus.mem_addr, bus.act_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    thr_v = '0; bus.thresholds = thr_v;
    for (int r = 5; r <= 7; r++)
      for (int l = 0; l < int'(L); l++) mem[r][l*PW +: PW] = PW'(1);
    run_readout(5, 3, 0, 1'b0);
    checks++;
    if (timed_out || rec_addr.size() != 3 || rec_word.size() != 3) begin
      errors++;
      $display("FAIL basic_counts reads=%0d words=%0d timeout=%0d exp=3/3/0",
               rec_addr.size(), rec_word.size(), timed_out);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rec_addr[k] != 5 + k || rec_issue_cyc[k] != rec_issue_cyc[0] + k) begin
          errors++;
          $display("FAIL basic_addr[%0d] got=%0d@%0d exp=%0d consecutive", k, rec_addr[k],
                   rec_issue_cyc[k], 5 + k);
        end
        checks++;
        if (rec_word[k] !== 32'hFFFF_FFFF || rec_last[k] !== (k == 2)) begin
          errors++;
          $display("FAIL basic_word[%0d] got=%h last=%0d exp=ffffffff last=%0d", k,
                   rec_word[k], rec_last[k], k == 2);
        end
      end
      checks++;
      if (rec_hs_cyc[0] != rec_issue_cyc[0] + 2) begin
        errors++;
        $display("FAIL basic_latency got=%0d exp=%0d", rec_hs_cyc[0], rec_issue_cyc[0] + 2);
      end
      checks++;
      if (done_cyc != rec_hs_cyc[2] + 1 || done_cnt != 1) begin
        errors++;
        $display("FAIL basic_done got=%0d cnt=%0d exp=%0d cnt=1", done_cyc, done_cnt,
                 rec_hs_cyc[2] + 1);
      end
    end
    checks++;
    if (busy_gaps != 0 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy gaps=%0d busy_at_done=%0d exp=0/0", busy_gaps, busy_at_done);
    end
  endtask

  task automatic test_signed_compare();
    logic [L-1:0] exp_w;
    set_random_thr();
    thr_v[0*PW +: PW] = 16'sd0;      mem[40][0*PW +: PW] = -16'sd1;
    thr_v[1*PW +: PW] = 16'sd7;      mem[40][1*PW +: PW] = 16'sd7;
    thr_v[2*PW +: PW] = -16'sd32767; mem[40][2*PW +: PW] = 16'h8000;
    thr_v[3*PW +: PW] = 16'h8000;    mem[40][3*PW +: PW] = 16'sd32767;
    bus.thresholds = thr_v;
    exp_w = ref_word(40);
    run_readout(40, 1, 0, 1'b0);
    checks++;
    if (timed_out || rec_word.size() != 1) begin
      errors++;
      $display("FAIL signed_count got=%0d timeout=%0d exp=1/0", rec_word.size(), timed_out);
    end else begin
      checks++;
      if (rec_word[0][3:0] !== 4'b1010) begin
        errors++;
        $display("FAIL signed_low4 got=%b exp=1010", rec_word[0][3:0]);
      end
      checks++;
      if (rec_word[0] !== exp_w || rec_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL signed_word got=%h last=%0d exp=%h last=1", rec_word[0], rec_last[0], exp_w);
      end
    end
  endtask

  task automatic test_backpressure();
    set_random_thr();
    run_readout(600, 6, 1, 1'b0);
    checks++;
    if (timed_out || rec_word.size() != 6 || rec_addr.size() != 6) begin
      errors++;
      $display("FAIL bp_counts words=%0d reads=%0d timeout=%0d exp=6/6/0",
               rec_word.size(), rec_addr.size(), timed_out);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (rec_word[k] !== ref_word(600 + k) || rec_last[k] !== (k == 5)) begin
          errors++;
          $display("FAIL bp_word[%0d] got=%h last=%0d exp=%h last=%0d", k, rec_word[k],
                   rec_last[k], ref_word(600 + k), k == 5);
        end
      end
    end
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL bp_outstanding got=%0d exp<=2", max_out);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL bp_stable got=%0d exp=0", stall_viol);
    end
  endtask

  task automatic test_wrap();
    set_random_thr();
    run_readout(2046, 4, 0, 1'b0);
    checks++;
    if (timed_out || rec_addr.size() != 4 || rec_word.size() != 4) begin
      errors++;
      $display("FAIL wrap_counts reads=%0d words=%0d exp=4/4", rec_addr.size(), rec_word.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rec_addr[k] != (2046 + k) % int'(NROWS) ||
            rec_word[k] !== ref_word((2046 + k) % NROWS)) begin
          errors++;
          $display("FAIL wrap[%0d] addr=%0d data=%h exp addr=%0d data=%h", k, rec_addr[k],
                   rec_word[k], (2046 + k) % int'(NROWS), ref_word((2046 + k) % NROWS));
        end
      end
    end
  endtask

  task automatic test_zero_batch();
    run_readout(77, 0, 0, 1'b0);
    checks++;
    if (timed_out || done_cyc != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_done got=%0d cnt=%0d exp=1 cnt=1", done_cyc, done_cnt);
    end
    checks++;
    if (rec_addr.size() != 0 || valid_cyc_cnt != 0) begin
      errors++;
      $display("FAIL zero_quiet reads=%0d valid_cycles=%0d exp=0/0", rec_addr.size(), valid_cyc_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int hs, dcnt, cyc;
    hs = 0; dcnt = 0;
    set_random_thr();
    bus.act_ready = 1'b1;
    for (cyc = 0; cyc < 100 && hs < 2; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == 0);
      bus.address_start = AW'(100);
      bus.batch = CW'(6);
      #1;
      if (bus.act_valid && bus.act_ready) hs++;
      if (bus.done) dcnt++;
    end
    bus.start = 1'b0;
    checks++;
    if (hs < 2) begin
      errors++;
      $display("FAIL rst_mid_progress got=%0d exp=2", hs);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.mem_en, bus.act_valid, bus.act_last, bus.busy, bus.done} !== 5'b0 ||
        bus.mem_addr !== '0 || bus.act_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs ctrl=%b addr=%0h data=%0h exp=0",
               {bus.mem_en, bus.act_valid, bus.act_last, bus.busy, bus.done},
               bus.mem_addr, bus.act_data);
    end
    repeat (2) begin
      @(negedge clk); #1;
      if (bus.done) dcnt++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus.done || bus.busy || bus.mem_en || bus.act_valid) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL rst_mid_no_done got=%0d exp=0", dcnt);
    end
    run_readout(300, 2, 0, 1'b0);
    checks++;
    if (timed_out || rec_word.size() != 2 || done_cnt != 1 ||
        rec_word[0] !== ref_word(300) || rec_word[1] !== ref_word(301) ||
        rec_last[1] !== 1'b1 || done_cyc != rec_hs_cyc[1] + 1) begin
      errors++;
      $display("FAIL rst_mid_restart words=%0d done=%0d cnt=%0d exp=2 words after last hs, cnt=1",
               rec_word.size(), done_cyc, done_cnt);
    end
  endtask

  task automatic test_random();
    int a, n, mode;
    for (int it = 0; it < 6; it++) begin
      set_random_thr();
      a    = $urandom_range(0, NROWS - 1);
      n    = $urandom_range(1, 20);
      mode = (it % 2 == 0) ? 2 : 0;
      run_readout(a, n, mode, 1'b1);
      checks++;
      if (timed_out || rec_word.size() != n || rec_addr.size() != n) begin
        errors++;
        $display("FAIL rand%0d_counts words=%0d reads=%0d timeout=%0d exp=%0d", it,
                 rec_word.size(), rec_addr.size(), timed_out, n);
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (rec_addr[k] != (a + k) % int'(NROWS) ||
              rec_word[k] !== ref_word((a + k) % NROWS) || rec_last[k] !== (k == n - 1)) begin
            errors++;
            $display("FAIL rand%0d_word[%0d] addr=%0d data=%h last=%0d exp addr=%0d data=%h last=%0d",
                     it, k, rec_addr[k], rec_word[k], rec_last[k], (a + k) % int'(NROWS),
                     ref_word((a + k) % NROWS), k == n - 1);
          end
        end
        checks++;
        if (done_cyc != rec_hs_cyc[n-1] + 1 || done_cnt != 1 || max_out > 2 || stall_viol != 0) begin
          errors++;
          $display("FAIL rand%0d_flow done=%0d cnt=%0d out=%0d stall=%0d exp done=%0d cnt=1 out<=2 stall=0",
                   it, done_cyc, done_cnt, max_out, stall_viol, rec_hs_cyc[n-1] + 1);
        end
      end
    end
  endtask

  initial begin
    fill_random_mem();
    test_reset();
    test_basic();
    test_signed_compare();
    test_backpressure();
    test_wrap();
    test_zero_batch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
